// File: rtl/cs_pkg.sv
// cs_pkg: mode encodings, wait FSM state type and default wait width for cs_decoder.
// Wait-state support is enabled in the design by defining CS_WAIT_EN.
package cs_pkg;

    localparam int CS_WAIT_W = 4;

    typedef enum logic [1:0] {
        CS_MODE_ANY = 2'b00,
        CS_MODE_RD  = 2'b01,
        CS_MODE_WR  = 2'b10,
        CS_MODE_OFF = 2'b11
    } cs_mode_e;

    typedef enum logic {
        CS_IDLE = 1'b0,
        CS_WAIT = 1'b1
    } cs_wait_state_e;

    // RW is 1 for a read cycle and 0 for a write cycle.
    function automatic logic cs_mode_allows(input cs_mode_e mode, input logic rw);
        logic ok;
        case (mode)
            CS_MODE_ANY: ok = 1'b1;
            CS_MODE_RD:  ok = rw;
            CS_MODE_WR:  ok = ~rw;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cs_channel.sv
// cs_channel: config registers and address/direction match for one decode window.
// The per-channel wait register exists only when CS_WAIT_EN is defined.
module cs_channel
    import cs_pkg::*;
#(
    parameter int AW  = 16,
    parameter int SW  = 2,
    parameter int IDX = 0
`ifdef CS_WAIT_EN
    , parameter int WAIT_W = CS_WAIT_W
`endif
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_we,
    input  logic [SW-1:0]     i_sel,
    input  logic [AW-1:0]     i_mask,
    input  logic [AW-1:0]     i_pattern,
    input  logic [1:0]        i_mode,
`ifdef CS_WAIT_EN
    input  logic [WAIT_W-1:0] i_wait,
    output logic [WAIT_W-1:0] o_wait,
`endif
    input  logic [AW-1:0]     i_addr,
    input  logic              i_rw,
    output logic              o_match
);

    logic [AW-1:0] r_mask;
    logic [AW-1:0] r_pattern;
    cs_mode_e      r_mode;
    logic          w_we;

    // A select value with no matching channel index writes nothing.
    assign w_we = i_we && (i_sel == SW'(IDX));

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_mask    <= '0;
            r_pattern <= '0;
            r_mode    <= CS_MODE_OFF;
        end else if (w_we) begin
            r_mask    <= i_mask;
            r_pattern <= i_pattern;
            r_mode    <= cs_mode_e'(i_mode);
        end
    end

`ifdef CS_WAIT_EN
    logic [WAIT_W-1:0] r_wait;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_wait <= '0;
        end else if (w_we) begin
            r_wait <= i_wait;
        end
    end

    assign o_wait = r_wait;
`endif

    assign o_match = (((i_addr ^ r_pattern) & r_mask) == '0) && cs_mode_allows(r_mode, i_rw);

endmodule

// File: rtl/cs_decoder.sv
// cs_decoder: PHI2-synchronised, priority chip-select decoder with programmable windows.
// Define CS_WAIT_EN to build the RDY wait-state generator; otherwise RDY is tied high.
module cs_decoder
    import cs_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int AW       = 16,
    parameter  int WAIT_W   = CS_WAIT_W,
    localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                PHI2,
    input  logic                RW,
    input  logic [AW-1:0]       A,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_sel,
    input  logic [AW-1:0]       cfg_mask,
    input  logic [AW-1:0]       cfg_pattern,
    input  logic [1:0]          cfg_mode,
    input  logic [WAIT_W-1:0]   cfg_wait,
    output logic [CHANNELS-1:0] ceN,
    output logic                hit,
    output logic [SW-1:0]       hit_idx,
    output logic                RDY
);

    logic                r_pMeta;
    logic                r_pSync;
    logic                r_pPrev;
    logic                w_phaseStart;
    logic                w_phaseEnd;
    logic [CHANNELS-1:0] w_match;
    logic                w_anyHit;
    logic [SW-1:0]       w_winIdx;
    logic [CHANNELS-1:0] w_ceNext;
    logic [CHANNELS-1:0] r_ceN;
    logic                r_hit;
    logic [SW-1:0]       r_hitIdx;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pMeta <= 1'b0;
            r_pSync <= 1'b0;
            r_pPrev <= 1'b0;
        end else begin
            r_pMeta <= PHI2;
            r_pSync <= r_pMeta;
            r_pPrev <= r_pSync;
        end
    end

    assign w_phaseStart = r_pSync & ~r_pPrev;
    assign w_phaseEnd   = ~r_pSync & r_pPrev;

`ifdef CS_WAIT_EN
    logic [WAIT_W-1:0] w_chWait [CHANNELS];
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        cs_channel #(
            .AW  (AW),
            .SW  (SW),
            .IDX (g)
`ifdef CS_WAIT_EN
            , .WAIT_W (WAIT_W)
`endif
        ) u_ch (
            .i_clk     (clk),
            .i_rstN    (rstN),
            .i_we      (cfg_we),
            .i_sel     (cfg_sel),
            .i_mask    (cfg_mask),
            .i_pattern (cfg_pattern),
            .i_mode    (cfg_mode),
`ifdef CS_WAIT_EN
            .i_wait    (cfg_wait),
            .o_wait    (w_chWait[g]),
`endif
            .i_addr    (A),
            .i_rw      (RW),
            .o_match   (w_match[g])
        );
    end

    // Scanning from the top down leaves the lowest matching index as winner.
    always_comb begin
        w_anyHit = 1'b0;
        w_winIdx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_anyHit = 1'b1;
                w_winIdx = SW'(i);
            end
        end
        w_ceNext = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            w_ceNext[i] = !(w_anyHit && (w_winIdx == SW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_ceN    <= '1;
            r_hit    <= 1'b0;
            r_hitIdx <= '0;
        end else if (w_phaseStart) begin
            r_ceN <= w_ceNext;
            r_hit <= w_anyHit;
            if (w_anyHit) begin
                r_hitIdx <= w_winIdx;
            end
        end else if (w_phaseEnd) begin
            r_ceN <= '1;
            r_hit <= 1'b0;
        end
    end

    assign ceN     = r_ceN;
    assign hit     = r_hit;
    assign hit_idx = r_hitIdx;

`ifdef CS_WAIT_EN
    cs_wait_state_e    r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_rdy;
    logic [WAIT_W-1:0] w_winWait;

    assign w_winWait = w_chWait[w_winIdx];

    // Once the count drains, the following phase is the completing access and must not reload.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= CS_IDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
        end else begin
            case (r_state)
                CS_IDLE: begin
                    if (w_phaseStart && w_anyHit && (w_winWait != '0)) begin
                        r_cnt   <= w_winWait;
                        r_rdy   <= 1'b0;
                        r_state <= CS_WAIT;
                    end
                end
                CS_WAIT: begin
                    if (w_phaseEnd && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - WAIT_W'(1);
                        if (r_cnt == WAIT_W'(1)) begin
                            r_rdy <= 1'b1;
                        end
                    end
                    if (w_phaseStart && (r_cnt == '0)) begin
                        r_state <= CS_IDLE;
                    end
                end
                default: r_state <= CS_IDLE;
            endcase
        end
    end

    assign RDY = r_rdy;
`else
    logic [WAIT_W-1:0] w_unusedWait;
    assign w_unusedWait = cfg_wait;
    assign RDY = 1'b1;
`endif

endmodule

// File: tb/tb_cs_decoder.sv
// tb_cs_decoder: scoreboard bench for cs_decoder; stimulus queues expected outputs, a monitor checks them.
// RDY expectations follow CS_WAIT_EN: scheduled values when defined, constant 1 otherwise.
module tb_cs_decoder;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        PHI2 = 1'b0;
    logic        RW = 1'b1;
    logic [15:0] A = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_mask = '0;
    logic [15:0] cfg_pattern = '0;
    logic [1:0]  cfg_mode = '0;
    logic [3:0]  cfg_wait = '0;
    logic [3:0]  ceN;
    logic        hit;
    logic [1:0]  hit_idx;
    logic        RDY;

    cs_decoder #(.CHANNELS(4), .AW(16), .WAIT_W(4)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .PHI2        (PHI2),
        .RW          (RW),
        .A           (A),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_mask    (cfg_mask),
        .cfg_pattern (cfg_pattern),
        .cfg_mode    (cfg_mode),
        .cfg_wait    (cfg_wait),
        .ceN         (ceN),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .RDY         (RDY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cycle;
        logic [3:0]  ceN;
        logic        hit;
        logic [1:0]  idx;
        logic        rdy;
    } exp_t;

    exp_t  sbQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    logic [3:0] expCeN = 4'hF;
    logic       expHit = 1'b0;
    logic [1:0] expIdx = 2'd0;
    logic       expRdy = 1'b1;

    logic [1:0]  midSel = '0;
    logic [15:0] midMask = '0;
    logic [15:0] midPattern = '0;
    logic [1:0]  midMode = '0;
    logic [3:0]  midWait = '0;

    function automatic logic rdyModel(input logic v);
`ifdef CS_WAIT_EN
        return v;
`else
        return v | 1'b1;
`endif
    endfunction

    task automatic pushExp(input int atCycle, input string tag);
        exp_t e;
        e.cycle = atCycle;
        e.ceN   = expCeN;
        e.hit   = expHit;
        e.idx   = expIdx;
        e.rdy   = expRdy;
        sbQ.push_back(e);
        nameQ.push_back(tag);
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        checks++;
        if ({ceN, hit, hit_idx, RDY} !== {e.ceN, e.hit, e.idx, e.rdy}) begin
            errors++;
            $display("[TB] FAIL %s cyc %0d: got ceN=%h hit=%b idx=%0d RDY=%b, want ceN=%h hit=%b idx=%0d RDY=%b",
                     tag, cyc, ceN, hit, hit_idx, RDY, e.ceN, e.hit, e.idx, e.rdy);
        end
    endtask

    // Monitor: compare every queued expectation on the falling edge of its scheduled cycle.
    initial begin
        exp_t  e;
        string tag;
        forever begin
            @(negedge clk);
            while (sbQ.size() > 0 && int'(sbQ[0].cycle) <= cyc) begin
                e   = sbQ.pop_front();
                tag = nameQ.pop_front();
                checkOutput(e, tag);
            end
        end
    end

    task automatic cfgWrite(input logic [1:0] sel, input logic [15:0] mask, input logic [15:0] pattern,
                            input logic [1:0] mode, input logic [3:0] waitCycles);
        @(posedge clk); #1;
        cfg_sel = sel; cfg_mask = mask; cfg_pattern = pattern; cfg_mode = mode; cfg_wait = waitCycles;
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic phiRise(input logic [15:0] addr, input logic rw, input logic eHit, input logic [1:0] eIdx,
                           input logic eRdy, input string tag);
        int k;
        @(posedge clk); #1;
        A = addr; RW = rw;
        repeat (4) @(posedge clk);
        #1;
        k = cyc;
        PHI2 = 1'b1;
        pushExp(k + 2, {tag, ":preRise"});
        expCeN = eHit ? ~(4'b0001 << eIdx) : 4'hF;
        expHit = eHit;
        if (eHit) expIdx = eIdx;
        expRdy = rdyModel(eRdy);
        pushExp(k + 3, {tag, ":rise"});
    endtask

    task automatic phiFall(input logic eRdy, input string tag);
        int k;
        @(posedge clk); #1;
        k = cyc;
        PHI2 = 1'b0;
        pushExp(k + 2, {tag, ":preFall"});
        expCeN = 4'hF;
        expHit = 1'b0;
        expRdy = rdyModel(eRdy);
        pushExp(k + 3, {tag, ":fall"});
        repeat (4) @(posedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic eHit, input logic [1:0] eIdx,
                                 input logic rdyRise, input logic rdyFall, input bit midWr, input string tag);
        phiRise(addr, rw, eHit, eIdx, rdyRise, tag);
        repeat (4) @(posedge clk);
        if (midWr) begin
            cfgWrite(midSel, midMask, midPattern, midMode, midWait);
            pushExp(cyc + 2, {tag, ":afterCfg"});
        end
        repeat (4) @(posedge clk);
        phiFall(rdyFall, tag);
    endtask

    task automatic doReset(input string tag);
        @(posedge clk); #1;
        rstN = 1'b0;
        expCeN = 4'hF; expHit = 1'b0; expIdx = 2'd0; expRdy = 1'b1;
        pushExp(cyc + 1, tag);
        repeat (2) @(posedge clk);
        #1;
        PHI2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        $display("[TB] cs_decoder bench start");
        doReset("reset");

        applyStimulus(16'h8000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "allOff");

        cfgWrite(2'd0, 16'h8000, 16'h8000, 2'b00, 4'd0);
        cfgWrite(2'd1, 16'hF000, 16'h8000, 2'b00, 4'd0);
        applyStimulus(16'h8123, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, "prioRd");
        applyStimulus(16'h8123, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, "prioWr");
        applyStimulus(16'h0123, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "noMatch");

        cfgWrite(2'd0, 16'h8000, 16'h8000, 2'b11, 4'd0);
        cfgWrite(2'd1, 16'hF000, 16'h8000, 2'b11, 4'd0);
        cfgWrite(2'd2, 16'hC000, 16'hC000, 2'b01, 4'd0);
        applyStimulus(16'hC000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, "rdOnlyRd");
        applyStimulus(16'hC000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, "rdOnlyWr");
        applyStimulus(16'hE000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, "rdOnlyE000");

        midSel = 2'd3; midMask = 16'h0000; midPattern = 16'h0000; midMode = 2'b00; midWait = 4'd0;
        applyStimulus(16'h4000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, "midCfg");
        applyStimulus(16'h4000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, "ch3Rd");
        applyStimulus(16'h4000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, "ch3Wr");

        cfgWrite(2'd0, 16'h8000, 16'h8000, 2'b00, 4'd2);
        applyStimulus(16'h8000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, "wait1");
        applyStimulus(16'h8000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, "wait2");
        applyStimulus(16'h8000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, "waitDone");

        phiRise(16'h8000, 1'b1, 1'b1, 2'd0, 1'b0, "reload");
        repeat (4) @(posedge clk);
        doReset("midReset");

        applyStimulus(16'h8000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "postReset");

        repeat (10) @(posedge clk);
        while (sbQ.size() > 0) begin
            exp_t  e;
            string tag;
            e   = sbQ.pop_front();
            tag = nameQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d never compared, want ceN=%h hit=%b idx=%0d RDY=%b",
                     tag, e.cycle, e.ceN, e.hit, e.idx, e.rdy);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
